// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU phase sequencer and its run controller:
// phase encodings, controller state type and the phase legality check.
package cpu_pkg;

    localparam logic [3:0] PH_IDLE = 4'b0000;
    localparam logic [3:0] PH_F    = 4'b0001;
    localparam logic [3:0] PH_D    = 4'b0010;
    localparam logic [3:0] PH_E    = 4'b0100;
    localparam logic [3:0] PH_W    = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_HALT
    } state_t;

    // Idle or exactly one phase bit set; anything else means the sequencer is corrupt.
    function automatic logic is_legal_phase(input logic [3:0] ph);
        case (ph)
            PH_IDLE, PH_F, PH_D, PH_E, PH_W: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Button synchronizer: SYNC_STAGES-flop chain followed by a rising-edge detector.
// A held button produces a single one-cycle rise pulse.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the asynchronous level through the chain and remember the last synced value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/run_ctrl.sv
// Run controller for the 4-phase one-hot CPU sequencer. Converts RUN/STEP buttons
// and the execute-stage halt request into start/stop levels, counts retired
// instructions and latches a sticky error on an illegal phase vector.
module run_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned CW          = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [3:0]    phase,
    input  logic          run_req,
    input  logic          step_req,
    input  logic          halt_req,
    input  logic          clr_cnt,
    output logic          start,
    output logic          stop,
    output logic          busy,
    output logic          halted,
    output logic [CW-1:0] icount,
    output logic          err
);

    state_t state, state_n;
    logic   pend, pend_n;
    logic   step_mode, step_n;
    logic   hflag, hflag_n;
    logic   run_rise, step_rise;
    logic   phase_ok;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
        .clk   (CLK),
        .rst_n (RSTN),
        .din   (run_req),
        .rise  (run_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clk   (CLK),
        .rst_n (RSTN),
        .din   (step_req),
        .rise  (step_rise)
    );

    assign phase_ok = is_legal_phase(phase);

    // Next-state and next-flag decision; outputs are registered from these below.
    always_comb begin
        state_n = state;
        pend_n  = pend;
        step_n  = step_mode;
        hflag_n = hflag;
        case (state)
            S_IDLE: begin
                if (run_rise) begin
                    state_n = S_START;
                    step_n  = 1'b0;
                end else if (step_rise) begin
                    state_n = S_START;
                    step_n  = 1'b1;
                end
            end
            S_START: begin
                if (phase == PH_F) begin
                    state_n = S_RUN;
                    pend_n  = step_mode;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    pend_n  = 1'b1;
                    hflag_n = 1'b1;
                end
                if (run_rise || step_mode) begin
                    pend_n = 1'b1;
                end
                if (phase == PH_W && pend) begin
                    // A halt arriving on the very retire cycle of a pending stop still halts.
                    state_n = (hflag || halt_req) ? S_HALT : S_IDLE;
                    pend_n  = 1'b0;
                    step_n  = 1'b0;
                    hflag_n = 1'b0;
                end
            end
            S_HALT: begin
                state_n = S_HALT;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (!phase_ok) begin
            state_n = S_HALT;
        end
    end

    // Controller state, flags and registered start/stop/busy/halted decodes plus sticky err.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_IDLE;
            pend      <= 1'b0;
            step_mode <= 1'b0;
            hflag     <= 1'b0;
            start     <= 1'b0;
            stop      <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            step_mode <= step_n;
            hflag     <= hflag_n;
            start     <= (state_n == S_START);
            stop      <= (state_n == S_HALT) || ((state_n == S_RUN) && pend_n);
            busy      <= (state_n == S_START) || (state_n == S_RUN);
            halted    <= (state_n == S_HALT);
            err       <= err | ~phase_ok;
        end
    end

    // Retired-instruction counter: one count per write-back cycle, clear has priority.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            icount <= '0;
        end else if (clr_cnt) begin
            icount <= '0;
        end else if (phase == PH_W) begin
            icount <= icount + CW'(1);
        end
    end

endmodule
